// File: rtl/pc_gen_pkg.sv
// pc_gen shared definitions: next-PC op codes (same values as
// ctrl_encode_def.v) and a helper that flags control-transfer ops.
package pc_gen_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  function automatic logic is_cti(input logic [2:0] op);
    return op inside {NPC_BRANCH, NPC_JUMP, NPC_JALR};
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Resolve bus from execute to pc_gen.
// Members: res_valid/op/taken/mispredict, res_pc, imm, aluout.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            res_valid;
  logic [2:0]      res_op;
  logic            res_taken;
  logic            res_mispredict;
  logic [XLEN-1:0] res_pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] aluout;

  modport master (
    output res_valid, res_op, res_taken,
    output res_mispredict, res_pc, imm, aluout
  );

  modport slave (
    input res_valid, res_op, res_taken,
    input res_mispredict, res_pc, imm, aluout
  );
endinterface

// File: rtl/pc_gen_btb.sv
// Direct-mapped BTB with 2-bit counters; lookup is combinational.
// Ports: clk, rstn, i_lk_pc -> o_lk_hit/taken/target; i_up_* update.
module pc_gen_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] i_lk_pc,
  output logic            o_lk_hit,
  output logic            o_lk_taken,
  output logic [XLEN-1:0] o_lk_target,
  input  logic            i_up_en,
  input  logic [XLEN-1:0] i_up_pc,
  input  logic            i_up_taken,
  input  logic [XLEN-1:0] i_up_target
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = XLEN - IDX - 2;

  logic            r_valid [ENTRIES];
  logic [1:0]      r_ctr   [ENTRIES];
  logic [TW-1:0]   r_tag   [ENTRIES];
  logic [XLEN-1:0] r_tgt   [ENTRIES];

  logic [IDX-1:0] w_lk_idx;
  logic [IDX-1:0] w_up_idx;
  logic [TW-1:0]  w_lk_tag;
  logic [TW-1:0]  w_up_tag;
  logic           w_up_hit;

  assign w_lk_idx = i_lk_pc[IDX+1:2];
  assign w_lk_tag = i_lk_pc[XLEN-1:IDX+2];
  assign w_up_idx = i_up_pc[IDX+1:2];
  assign w_up_tag = i_up_pc[XLEN-1:IDX+2];

  // Reads see pre-update contents; no write bypass.
  assign o_lk_hit    = r_valid[w_lk_idx] &&
                       (r_tag[w_lk_idx] == w_lk_tag);
  assign o_lk_taken  = o_lk_hit && r_ctr[w_lk_idx][1];
  assign o_lk_target = r_tgt[w_lk_idx];

  assign w_up_hit = r_valid[w_up_idx] &&
                    (r_tag[w_up_idx] == w_up_tag);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'd0;
      end
    end else if (i_up_en) begin
      if (w_up_hit) begin
        if (i_up_taken) begin
          if (r_ctr[w_up_idx] != 2'd3)
            r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
        end else if (r_ctr[w_up_idx] != 2'd0) begin
          r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
        end
      end else if (i_up_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_ctr[w_up_idx]   <= 2'd2;
      end
    end
  end

  // Tag/target carry no reset; a taken update either installs
  // (new tag) or refreshes a hit (same tag), so one write covers both.
  always_ff @(posedge clk) begin
    if (rstn && i_up_en && i_up_taken) begin
      r_tag[w_up_idx] <= w_up_tag;
      r_tgt[w_up_idx] <= i_up_target;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with redirect, stall and optional BTB
// (macro PC_GEN_BTB_EN). Ports: clk, rstn, stall, res bus, pc/npc/pred.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  pc_gen_if.slave         res,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] npc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o
);
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_res_tgt;
  logic            w_redirect;
  logic            w_pred;
  logic [XLEN-1:0] w_pred_tgt;

  assign pc_o       = r_pc;
  assign w_pc4      = r_pc + XLEN'(4);
  assign w_redirect = res.res_valid && res.res_mispredict;

  always_comb begin
    w_res_tgt = res.res_pc + XLEN'(4);
    if (res.res_taken) begin
      unique case (1'b1)
        res.res_op == NPC_BRANCH,
        res.res_op == NPC_JUMP:
          w_res_tgt = res.res_pc + res.imm;
        res.res_op == NPC_JALR:
          w_res_tgt = res.aluout + res.imm;
        default: ;
      endcase
    end
  end

`ifdef PC_GEN_BTB_EN
  logic            w_lk_hit;
  logic            w_lk_taken;
  logic [XLEN-1:0] w_lk_tgt;
  logic            w_up_en;

  assign w_up_en = res.res_valid && is_cti(res.res_op);

  pc_gen_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rstn        (rstn),
    .i_lk_pc     (r_pc),
    .o_lk_hit    (w_lk_hit),
    .o_lk_taken  (w_lk_taken),
    .o_lk_target (w_lk_tgt),
    .i_up_en     (w_up_en),
    .i_up_pc     (res.res_pc),
    .i_up_taken  (res.res_taken),
    .i_up_target (w_res_tgt)
  );

  assign w_pred     = rstn && w_lk_taken;
  assign w_pred_tgt = w_lk_taken ? w_lk_tgt : w_pc4;
`else
  assign w_pred     = 1'b0;
  assign w_pred_tgt = w_pc4;
`endif

  assign pred_taken_o  = w_pred;
  assign pred_target_o = w_pred_tgt;

  // Redirect outranks stall; reset outranks everything.
  always_comb begin
    npc_o = w_pc4;
    if (!rstn) begin
      npc_o = RESET_PC;
    end else begin
      priority case (1'b1)
        w_redirect: npc_o = w_res_tgt;
        stall:      npc_o = r_pc;
        w_pred:     npc_o = w_pred_tgt;
        default:    npc_o = w_pc4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_pc <= RESET_PC;
    else       r_pc <= npc_o;
  end

endmodule
